uart_flash_bridge: RTL and testbench

UART_FLASH_BRIDGE -- requirements
Module: uart_flash_bridge

---
 rtl/uart_flash_bridge_pkg.sv | 22 ++
 rtl/bridge_buf.sv | 28 ++
 rtl/uart_flash_bridge.sv | 191 +++++++++++++++++++
 tb/tb_uart_flash_bridge.sv | 397 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_flash_bridge_pkg.sv
// Shared constants for the UART-to-flash bridge:
// command/status byte codes and the controller state encoding.
package uart_flash_bridge_pkg;

  localparam logic [7:0] CMD_RD = 8'h52;
  localparam logic [7:0] CMD_WR = 8'h57;
  localparam logic [7:0] ACK    = 8'h06;
  localparam logic [7:0] NAK    = 8'h15;

  typedef enum logic [3:0] {
    IDLE,
    ADDR,
    LEN,
    WDATA,
    FL_GO,
    FL_WAIT,
    TX_GO,
    TX_WAIT,
    STATUS
  } state_t;

endpackage

// File: rtl/bridge_buf.sv
// Write-burst buffer: single port, synchronous write, registered read.
// The read register doubles as the flash write-data output.
module bridge_buf #(
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we,
  input  logic          re,
  input  logic [AW-1:0] addr,
  input  logic [7:0]    wdata,
  output logic [7:0]    rdata
);

  logic [7:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
  end

  // Held between reads so it stays stable for a whole flash access.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) rdata <= '0;
    else if (re) rdata <= mem[addr];
  end

endmodule

// File: rtl/uart_flash_bridge.sv
// Byte-protocol bridge from a UART to a simple flash access port:
// read/write bursts, timeout, overrun detection and ACK/NAK status.
module uart_flash_bridge
  import uart_flash_bridge_pkg::*;
#(
  parameter int ADDR_W      = 22,
  parameter int ADDR_BYTES  = 3,
  parameter int MAX_BURST   = 16,
  parameter int TIMEOUT_CYC = 5_000_000
) (
  input  logic              CLK_50MHZ,
  input  logic              RST,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic [7:0]        tx_data,
  output logic              tx_start,
  input  logic              tx_busy,
  output logic [ADDR_W-1:0] fl_addr,
  output logic [7:0]        fl_wdata,
  input  logic [7:0]        fl_rdata,
  output logic              fl_rw,
  output logic              fl_start,
  input  logic              fl_done,
  output logic              busy
);

  localparam int BW = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  localparam int CW = (ADDR_BYTES > 1) ? $clog2(ADDR_BYTES) : 1;

  state_t state, nxt;

  logic              rd, err, ovr, fin, seen;
  logic [CW-1:0]     acnt;
  logic [7:0]        len, idx;
  logic [ADDR_W-1:0] addr;
  logic [TW-1:0]     tmo;
  logic              rx_st, tmo_hit, last;
  logic              cmd_ok, len_ok, tx_done;
  logic              buf_we, buf_re;

  assign rx_st   = (state == ADDR) || (state == LEN) ||
                   (state == WDATA);
  assign tmo_hit = rx_st && !rx_valid &&
                   (tmo == TW'(TIMEOUT_CYC - 1));
  assign last    = (idx == len - 8'd1);
  assign cmd_ok  = (rx_data == CMD_RD) || (rx_data == CMD_WR);
  assign len_ok  = (rx_data != 8'd0) &&
                   (rx_data <= 8'(MAX_BURST));
  assign tx_done = seen && !tx_busy;
  assign busy    = (state != IDLE);
  assign tx_start = (state == TX_GO) && !tx_busy;
  assign buf_we  = (state == WDATA) && rx_valid;
  assign buf_re  = (state == FL_GO);

  bridge_buf #(
    .DEPTH (MAX_BURST),
    .AW    (BW)
  ) u_buf (
    .clk   (CLK_50MHZ),
    .rst   (RST),
    .we    (buf_we),
    .re    (buf_re),
    .addr  (BW'(idx)),
    .wdata (rx_data),
    .rdata (fl_wdata)
  );

  always_ff @(posedge CLK_50MHZ or posedge RST) begin
    if (RST) state <= IDLE;
    else state <= nxt;
  end

  always_comb begin
    nxt = state;
    unique case (state)
      IDLE:
        if (rx_valid) nxt = cmd_ok ? ADDR : STATUS;
      ADDR:
        if (tmo_hit) nxt = STATUS;
        else if (rx_valid &&
                 acnt == CW'(ADDR_BYTES - 1))
          nxt = LEN;
      LEN:
        if (tmo_hit) nxt = STATUS;
        else if (rx_valid)
          nxt = !len_ok ? STATUS :
                (rd ? FL_GO : WDATA);
      WDATA:
        if (tmo_hit) nxt = STATUS;
        else if (rx_valid && last) nxt = FL_GO;
      FL_GO:
        nxt = FL_WAIT;
      FL_WAIT:
        if (fl_done)
          nxt = rd ? TX_GO : (last ? STATUS : FL_GO);
      TX_GO:
        if (!tx_busy) nxt = TX_WAIT;
      TX_WAIT:
        if (tx_done)
          nxt = fin ? IDLE : (last ? STATUS : FL_GO);
      STATUS:
        nxt = TX_GO;
      default:
        nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK_50MHZ or posedge RST) begin
    if (RST) begin
      rd       <= 1'b0;
      err      <= 1'b0;
      ovr      <= 1'b0;
      fin      <= 1'b0;
      seen     <= 1'b0;
      acnt     <= '0;
      len      <= '0;
      idx      <= '0;
      addr     <= '0;
      tmo      <= '0;
      tx_data  <= '0;
      fl_addr  <= '0;
      fl_rw    <= 1'b1;
      fl_start <= 1'b0;
    end else begin
      fl_start <= 1'b0;
      tmo <= (rx_st && !rx_valid) ? tmo + 1'b1 : '0;
      if (rx_valid && !rx_st && state != IDLE) ovr <= 1'b1;
      if (tmo_hit) err <= 1'b1;
      unique case (state)
        IDLE:
          if (rx_valid) begin
            rd   <= (rx_data == CMD_RD);
            acnt <= '0;
            err  <= !cmd_ok;
          end
        ADDR:
          if (rx_valid) begin
            // Shifting MSB-first drops bits above ADDR_W.
            addr <= ADDR_W'({addr, rx_data});
            acnt <= acnt + 1'b1;
          end
        LEN:
          if (rx_valid) begin
            len <= rx_data;
            idx <= '0;
            if (!len_ok) err <= 1'b1;
          end
        WDATA:
          if (rx_valid) idx <= last ? 8'd0 : idx + 8'd1;
        FL_GO: begin
          fl_start <= 1'b1;
          fl_addr  <= addr;
          fl_rw    <= rd;
        end
        FL_WAIT:
          if (fl_done) begin
            if (rd) begin
              tx_data <= fl_rdata;
            end else begin
              idx  <= idx + 8'd1;
              addr <= addr + 1'b1;
            end
          end
        TX_GO:
          seen <= 1'b0;
        TX_WAIT:
          if (tx_done) begin
            seen <= 1'b0;
            if (!fin) begin
              idx  <= idx + 8'd1;
              addr <= addr + 1'b1;
            end
          end else if (tx_busy) begin
            seen <= 1'b1;
          end
        STATUS: begin
          tx_data <= (err || ovr) ? NAK : ACK;
          fin     <= 1'b1;
        end
        default: ;
      endcase
      if (nxt == IDLE) begin
        ovr <= 1'b0;
        err <= 1'b0;
        fin <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_flash_bridge.sv
// Bench for uart_flash_bridge: directed scenarios plus random commands,
// checked against a queue-based protocol model with flash/UART models.
module tb_uart_flash_bridge;
  import uart_flash_bridge_pkg::*;

  localparam int AW = 22;
  localparam int AB = 3;
  localparam int MB = 16;
  localparam int TO = 100;

  typedef struct packed {
    logic [AW-1:0] a;
    logic          rw;
    logic [7:0]    d;
  } acc_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [7:0]    rx_data = 8'h00;
  logic          rx_valid = 1'b0;
  logic [7:0]    tx_data;
  logic          tx_start;
  logic          tx_busy = 1'b0;
  logic [AW-1:0] fl_addr;
  logic [7:0]    fl_wdata;
  logic [7:0]    fl_rdata = 8'h00;
  logic          fl_rw;
  logic          fl_start;
  logic          fl_done = 1'b0;
  logic          busy;

  always #5 clk = ~clk;

  uart_flash_bridge #(
    .ADDR_W      (AW),
    .ADDR_BYTES  (AB),
    .MAX_BURST   (MB),
    .TIMEOUT_CYC (TO)
  ) dut (
    .CLK_50MHZ (clk),
    .RST       (rst),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .tx_data   (tx_data),
    .tx_start  (tx_start),
    .tx_busy   (tx_busy),
    .fl_addr   (fl_addr),
    .fl_wdata  (fl_wdata),
    .fl_rdata  (fl_rdata),
    .fl_rw     (fl_rw),
    .fl_start  (fl_start),
    .fl_done   (fl_done),
    .busy      (busy)
  );

  int vectors = 0;
  int errors  = 0;
  int cyc     = 0;

  acc_t       exp_fl[$];
  logic [7:0] exp_tx[$];
  logic [7:0] ref_mem [logic [AW-1:0]];
  logic [7:0] fmem    [logic [AW-1:0]];

  logic       fl_pend = 1'b0;
  acc_t       fl_cur;
  acc_t       fe;
  int         fl_cnt = 0;
  logic       tx_act = 1'b0;
  logic       tx_dly = 1'b0;
  int         tx_left = 0;
  logic [7:0] tx_cur;
  int         tx_end_cyc = 0;
  int         lat_ref = -1;

  always @(posedge clk) cyc++;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  function automatic acc_t mk(input logic [AW-1:0] a, input logic rw,
                              input logic [7:0] d);
    acc_t r;
    r.a = a;
    r.rw = rw;
    r.d = d;
    return r;
  endfunction

  // Erased flash is not modelled; untouched cells hold an address hash.
  function automatic logic [7:0] seed_byte(input logic [AW-1:0] a);
    return a[7:0] ^ a[15:8] ^ {2'b00, a[21:16]} ^ 8'h5A;
  endfunction

  function automatic logic [7:0] ref_rd(input logic [AW-1:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : seed_byte(a);
  endfunction

  function automatic logic [7:0] fl_peek(input logic [AW-1:0] a);
    return fmem.exists(a) ? fmem[a] : seed_byte(a);
  endfunction

  // Flash and UART models plus the per-cycle output checker.
  always @(negedge clk) begin
    if (!rst) begin
      fl_done = 1'b0;
      if (fl_pend) begin
        chk("fl_start_pulse", fl_start, 0);
        chk("fl_addr_hold", fl_addr, fl_cur.a);
        chk("fl_rw_hold", fl_rw, fl_cur.rw);
        if (!fl_cur.rw) chk("fl_wdata_hold", fl_wdata, fl_cur.d);
        if (fl_cnt == 0) begin
          fl_done = 1'b1;
          fl_pend = 1'b0;
          if (fl_cur.rw) fl_rdata = fl_peek(fl_cur.a);
          else fmem[fl_cur.a] = fl_cur.d;
        end else begin
          fl_cnt--;
        end
      end else if (fl_start) begin
        fl_cur = mk(fl_addr, fl_rw, fl_wdata);
        fl_pend = 1'b1;
        fl_cnt = $urandom_range(0, 3);
        if (exp_fl.size() == 0) begin
          vectors++;
          errors++;
          $display("FAIL fl_extra: got addr %0h rw %0d want none",
                   fl_addr, fl_rw);
        end else begin
          fe = exp_fl.pop_front();
          chk("fl_addr", fl_addr, fe.a);
          chk("fl_rw", fl_rw, fe.rw);
          if (!fe.rw) chk("fl_wdata", fl_wdata, fe.d);
        end
        if (lat_ref >= 0) begin
          chk("fl_latency", cyc - lat_ref, 2);
          lat_ref = -1;
        end
      end

      if (tx_act) begin
        chk("tx_start_pulse", tx_start, 0);
        chk("tx_data_hold", tx_data, tx_cur);
        if (tx_dly) begin
          tx_dly = 1'b0;
          tx_busy = 1'b1;
        end else if (tx_left == 0) begin
          tx_busy = 1'b0;
          tx_act = 1'b0;
          tx_end_cyc = cyc;
        end else begin
          tx_left--;
        end
      end else if (tx_start) begin
        chk("tx_busy_at_start", tx_busy, 0);
        tx_cur = tx_data;
        tx_act = 1'b1;
        tx_dly = 1'b1;
        tx_left = $urandom_range(0, 4);
        if (exp_tx.size() == 0) begin
          vectors++;
          errors++;
          $display("FAIL tx_extra: got %0h want none", tx_data);
        end else begin
          chk("tx_byte", tx_data, exp_tx.pop_front());
        end
      end
    end
  end

  task automatic send(input logic [7:0] b, input bit mark = 1'b0);
    repeat ($urandom_range(0, 2)) @(negedge clk);
    @(negedge clk);
    rx_data = b;
    rx_valid = 1'b1;
    if (mark) lat_ref = cyc;
    @(negedge clk);
    rx_valid = 1'b0;
    rx_data = 8'($urandom);
  endtask

  task automatic send_addr(input logic [23:0] ab);
    send(ab[23:16]);
    send(ab[15:8]);
    send(ab[7:0]);
  endtask

  task automatic wait_done();
    int n = 0;
    do begin
      @(negedge clk);
      #1;
      n++;
    end while ((busy || tx_act) && n < 3000);
    chk("done_in_time", n < 3000, 1);
    chk("tx_queue_empty", exp_tx.size(), 0);
    chk("fl_queue_empty", exp_fl.size(), 0);
    chk("idle_after_tx", (cyc - tx_end_cyc) <= 2, 1);
    exp_tx.delete();
    exp_fl.delete();
    lat_ref = -1;
  endtask

  task automatic chk_reset();
    chk("rst_busy", busy, 0);
    chk("rst_tx_start", tx_start, 0);
    chk("rst_fl_start", fl_start, 0);
    chk("rst_tx_data", tx_data, 0);
    chk("rst_fl_wdata", fl_wdata, 0);
    chk("rst_fl_addr", fl_addr, 0);
    chk("rst_fl_rw", fl_rw, 1);
  endtask

  task automatic queue_read(input logic [AW-1:0] a, input int n);
    for (int k = 0; k < n; k++) begin
      exp_fl.push_back(mk(AW'(a + AW'(k)), 1'b1, 8'h00));
      exp_tx.push_back(ref_rd(AW'(a + AW'(k))));
    end
  endtask

  task automatic run_random(input int kind);
    logic [23:0]   ab;
    logic [AW-1:0] a;
    logic [7:0]    wd[MB];
    logic [7:0]    c;
    int            n;
    ab = 24'($urandom);
    if ($urandom_range(0, 3) == 0)
      ab[AW-1:0] = 22'h3FFFFF - 22'($urandom_range(0, 5));
    a = ab[AW-1:0];
    n = $urandom_range(1, MB);
    if (kind == 0) begin
      for (int k = 0; k < n; k++) begin
        wd[k] = 8'($urandom);
        ref_mem[AW'(a + AW'(k))] = wd[k];
        exp_fl.push_back(mk(AW'(a + AW'(k)), 1'b0, wd[k]));
      end
      exp_tx.push_back(ACK);
      send(CMD_WR);
      send_addr(ab);
      send(8'(n));
      for (int k = 0; k < n; k++) send(wd[k], k == n - 1);
    end else if (kind == 1) begin
      queue_read(a, n);
      exp_tx.push_back(ACK);
      send(CMD_RD);
      send_addr(ab);
      send(8'(n), 1'b1);
    end else if (kind == 2) begin
      do c = 8'($urandom); while (c == CMD_RD || c == CMD_WR);
      exp_tx.push_back(NAK);
      send(c);
    end else begin
      n = $urandom_range(0, 1) ? 0 : $urandom_range(MB + 1, 255);
      exp_tx.push_back(NAK);
      send($urandom_range(0, 1) ? CMD_RD : CMD_WR);
      send_addr(ab);
      send(8'(n));
    end
    wait_done();
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: got no finish want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int            n;
    int            hits;
    logic [AW-1:0] a;
    repeat (3) @(negedge clk);
    #1;
    chk_reset();
    @(negedge clk);
    rst = 1'b0;

    // Write 3 bytes at 0x1F0.
    exp_fl.push_back(mk(22'h0001F0, 1'b0, 8'hAA));
    exp_fl.push_back(mk(22'h0001F1, 1'b0, 8'hBB));
    exp_fl.push_back(mk(22'h0001F2, 1'b0, 8'hCC));
    exp_tx.push_back(8'h06);
    ref_mem[22'h0001F0] = 8'hAA;
    ref_mem[22'h0001F1] = 8'hBB;
    ref_mem[22'h0001F2] = 8'hCC;
    send(8'h57); send(8'h00); send(8'h01); send(8'hF0);
    send(8'h03); send(8'hAA); send(8'hBB); send(8'hCC, 1'b1);
    wait_done();
    chk("flash_1f0", fl_peek(22'h0001F0), 8'hAA);
    chk("flash_1f1", fl_peek(22'h0001F1), 8'hBB);
    chk("flash_1f2", fl_peek(22'h0001F2), 8'hCC);

    // Read them back.
    exp_fl.push_back(mk(22'h0001F0, 1'b1, 8'h00));
    exp_fl.push_back(mk(22'h0001F1, 1'b1, 8'h00));
    exp_fl.push_back(mk(22'h0001F2, 1'b1, 8'h00));
    exp_tx.push_back(8'hAA);
    exp_tx.push_back(8'hBB);
    exp_tx.push_back(8'hCC);
    exp_tx.push_back(8'h06);
    send(8'h52); send(8'h00); send(8'h01); send(8'hF0);
    send(8'h03, 1'b1);
    wait_done();

    // Address wrap at the top of the space.
    exp_fl.push_back(mk(22'h3FFFFF, 1'b1, 8'h00));
    exp_fl.push_back(mk(22'h000000, 1'b1, 8'h00));
    exp_tx.push_back(seed_byte(22'h3FFFFF));
    exp_tx.push_back(seed_byte(22'h000000));
    exp_tx.push_back(8'h06);
    send(8'h52); send(8'h3F); send(8'hFF); send(8'hFF);
    send(8'h02, 1'b1);
    wait_done();

    // Unknown command.
    exp_tx.push_back(8'h15);
    send(8'h41);
    wait_done();

    // Write that stalls mid-data.
    exp_tx.push_back(8'h15);
    send(8'h57); send(8'h00); send(8'h00); send(8'h00);
    send(8'h02); send(8'h11);
    wait_done();

    // Overrun injected during the first flash access.
    a = AW'($urandom);
    queue_read(a, 4);
    exp_tx.push_back(8'h15);
    send(CMD_RD);
    send_addr({2'b00, a});
    send(8'd4, 1'b1);
    n = 0;
    do begin
      @(negedge clk);
      #1;
      n++;
    end while (!fl_pend && n < 200);
    chk("ovr_reach_flash", n < 200, 1);
    send(8'hEE);
    wait_done();

    for (int i = 0; i < 40; i++) begin
      n = $urandom_range(0, 9);
      run_random(n < 4 ? 0 : n < 8 ? 1 : n == 8 ? 2 : 3);
    end

    // Reset in the middle of an 8-byte read.
    a = AW'($urandom);
    queue_read(a, 8);
    exp_tx.push_back(ACK);
    send(CMD_RD);
    send_addr({2'b00, a});
    send(8'd8);
    hits = 0;
    n = 0;
    do begin
      @(negedge clk);
      #1;
      n++;
      if (fl_start) hits++;
    end while (hits < 2 && n < 500);
    chk("mid_burst_reached", hits, 2);
    rst = 1'b1;
    #1;
    chk("rst_drop_fl_start", fl_start, 0);
    chk("rst_drop_tx_start", tx_start, 0);
    chk("rst_drop_busy", busy, 0);
    exp_fl.delete();
    exp_tx.delete();
    fl_pend = 1'b0;
    fl_done = 1'b0;
    tx_act = 1'b0;
    tx_busy = 1'b0;
    lat_ref = -1;
    rx_valid = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    chk_reset();
    @(negedge clk);
    rst = 1'b0;
    run_random(1);
    run_random(0);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, errors);
    $finish;
  end

endmodule
